// File: rtl/seg7_scan_4.sv
// Scans a BCD MM:SS word onto a shared 4-digit, active-low 7-segment display with ghost guard, blink, colon and LZ blanking.
// Outputs are registered: one clock from the state change to the pins; no backpressure, and en=0 darkens the display on the next edge.
module seg7_scan_4 #(
  parameter int SCAN_DIV  = 6750,
  parameter int GHOST     = 16,
  parameter int BLINK_DIV = 13500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic        lz_sup,
  input  logic [3:0]  blink_mask,
  input  logic        colon_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GHOST - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE, GUARD, DRIVE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    slot_q, slot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [15:0]   snap_q, snap_d;
  logic          lz_q, lz_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          frame_done_q, frame_done_d;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  // Scan sequencing; the snapshot is refreshed only when a frame starts so a frame never tears.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    lz_d    = lz_q;
    if (!en) begin
      state_d = IDLE;
      slot_d  = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = GUARD;
          slot_d  = 2'd0;
          cnt_d   = '0;
          snap_d  = digits;
          lz_d    = lz_sup;
        end
        GUARD: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == GUARD_LAST) state_d = DRIVE;
        end
        DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            slot_d  = slot_q + 2'd1;
            state_d = GUARD;
            if (slot_q == 2'd3) begin
              snap_d = digits;
              lz_d   = lz_sup;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          slot_d  = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!en) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (state_q != IDLE) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Outputs are decoded from next-state values so the pins line up with the state they describe.
  always_comb begin
    case (slot_d)
      2'd0:    nib = snap_d[3:0];
      2'd1:    nib = snap_d[7:4];
      2'd2:    nib = snap_d[11:8];
      default: nib = snap_d[15:12];
    endcase
    blank = (lz_d && (snap_d[15:12] == 4'd0) && (slot_d == 2'd3)) ||
            (blink_mask[slot_d] && !blink_phase_d);
    an_d         = 4'hF;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    frame_done_d = 1'b0;
    if (state_d != IDLE) begin
      seg_d = seg_decode(nib);
      dp_d  = !(colon_en && (slot_d == 2'd2) && blink_phase_d);
      if ((state_d == DRIVE) && !blank) an_d = ~(4'b0001 << slot_d);
      frame_done_d = (state_d == DRIVE) && (slot_d == 2'd3) && (cnt_d == CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      slot_q        <= 2'd0;
      cnt_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      snap_q        <= 16'h0000;
      lz_q          <= 1'b0;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      an_q          <= 4'hF;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      cnt_q         <= cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      snap_q        <= snap_d;
      lz_q          <= lz_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_4.sv
// Directed bench for seg7_scan_4 with SCAN_DIV=8, GHOST=2, BLINK_DIV=64; checks on the falling edge.
module tb_seg7_scan_4;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] digits;
  logic        lz_sup;
  logic [3:0]  blink_mask;
  logic        colon_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int vectors;
  int miscompares;

  seg7_scan_4 #(.SCAN_DIV(8), .GHOST(2), .BLINK_DIV(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .digits     (digits),
    .lz_sup     (lz_sup),
    .blink_mask (blink_mask),
    .colon_en   (colon_en),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_dark(input string tag);
    check_vec({tag, "_an"}, 16'(an), 16'hF);
    check_vec({tag, "_seg"}, 16'(seg), 16'h7F);
    check_vec({tag, "_dp"}, 16'(dp), 16'h1);
    check_vec({tag, "_fd"}, 16'(frame_done), 16'h0);
  endtask

  // Leaves the bench on the first GUARD clock of slot 0 with a fresh snapshot.
  task automatic restart(input logic [15:0] d, input logic lz);
    en = 1'b0;
    @(negedge clk);
    digits = d;
    lz_sup = lz;
    en     = 1'b1;
    @(negedge clk);
  endtask

  // Checks one 32-clock frame starting at slot 0 clock 0; optionally changes digits mid-frame.
  task automatic run_frame(input string tag, input logic [27:0] segs, input logic [3:0] lit,
                           input logic dp_on, input int chg_k, input logic [15:0] chg_val);
    int         sl;
    logic [3:0] ea;
    logic       edp;
    for (int k = 0; k < 32; k++) begin
      sl  = k / 8;
      ea  = ((k % 8) >= 2 && lit[sl]) ? ~(4'b0001 << sl) : 4'hF;
      edp = (dp_on && sl == 2) ? 1'b0 : 1'b1;
      check_vec($sformatf("%s_an_k%0d", tag, k), 16'(an), 16'(ea));
      check_vec($sformatf("%s_seg_k%0d", tag, k), 16'(seg), 16'(segs[sl*7 +: 7]));
      check_vec($sformatf("%s_dp_k%0d", tag, k), 16'(dp), 16'(edp));
      check_vec($sformatf("%s_fd_k%0d", tag, k), 16'(frame_done), (k == 31) ? 16'h1 : 16'h0);
      if (k == chg_k) digits = chg_val;
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    en          = 1'b0;
    digits      = 16'h0000;
    lz_sup      = 1'b0;
    blink_mask  = 4'b0000;
    colon_en    = 1'b0;

    @(negedge clk);
    check_dark("reset");
    reset = 1'b0;
    @(negedge clk);
    check_dark("idle");

    // Segment words packed {slot3, slot2, slot1, slot0}.
    restart(16'h1234, 1'b0);
    run_frame("t1", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 1'b0, -1, 16'h0);
    run_frame("t2a", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 1'b0, 11, 16'h5678);
    run_frame("t2b", {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF, 1'b0, -1, 16'h0);

    restart(16'h0509, 1'b1);
    run_frame("t3lz", {7'h40, 7'h12, 7'h40, 7'h10}, 4'b0111, 1'b0, -1, 16'h0);
    restart(16'h0509, 1'b0);
    run_frame("t3nolz", {7'h40, 7'h12, 7'h40, 7'h10}, 4'hF, 1'b0, -1, 16'h0);

    blink_mask = 4'b0011;
    colon_en   = 1'b1;
    restart(16'h1234, 1'b0);
    run_frame("t4on0", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 1'b1, -1, 16'h0);
    run_frame("t4on1", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 1'b1, -1, 16'h0);
    run_frame("t4off0", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1100, 1'b0, -1, 16'h0);
    run_frame("t4off1", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1100, 1'b0, -1, 16'h0);
    run_frame("t4on2", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 1'b1, -1, 16'h0);
    blink_mask = 4'b0000;
    colon_en   = 1'b0;

    restart(16'h00A0, 1'b0);
    run_frame("t5", {7'h40, 7'h40, 7'h3F, 7'h40}, 4'hF, 1'b0, -1, 16'h0);

    // Drop en in slot 2 DRIVE, then re-enable.
    colon_en = 1'b1;
    restart(16'h1234, 1'b0);
    repeat (20) @(negedge clk);
    check_vec("t6_pre_an", 16'(an), 16'hB);
    check_vec("t6_pre_dp", 16'(dp), 16'h0);
    en = 1'b0;
    @(negedge clk);
    check_dark("t6_off");
    en = 1'b1;
    @(negedge clk);
    run_frame("t6_re", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 1'b1, -1, 16'h0);

    // Same again with an asynchronous reset pulse.
    restart(16'h1234, 1'b0);
    repeat (20) @(negedge clk);
    check_vec("t6r_pre_an", 16'(an), 16'hB);
    reset = 1'b1;
    #1;
    check_dark("t6r_async");
    @(negedge clk);
    check_dark("t6r_held");
    reset = 1'b0;
    @(negedge clk);
    run_frame("t6r_re", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 1'b1, -1, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
